riscv_top_level: RTL and testbench
==================================

Name: riscv_top_level

Overview:
- Board-level top of a minimal single-cycle RV32I computer for a 50 MHz FPGA board.
- Contains PC, instruction memory, register file, ALU, data memory and display logic.
- Switches, keys, LEDs and six seven-segment digits are the only external interface.
- A bench preloads instruction memory through the internal load hooks, releases reset, then watches the internal signal datapath_output.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words; byte address is program_counter[7:0].
- DMEM_WORDS, 64, data memory depth in 32-bit words; word index is addr[7:2].

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- KEY  in  4  KEY[3] is rst_n: asynchronous, active-low reset. KEY[2:0] unused.
- SW  in  10  SW[0] selects display source: 0 = datapath_output, 1 = program_counter. SW[9:1] unused.
- LEDR  out  10  datapath_output[9:0].
- HEX0..HEX5  out  7 each  active-low segments, HEX0 = least significant nibble.

Behaviour:
- Internal names are fixed, because the verification bench drives them hierarchically:
  - program_counter: logic [7:0] PC register.
  - test_write: logic variable, no continuous RTL driver, initialised to 0.
  - dummy_instr_writedata: logic [31:0] variable, no continuous RTL driver, initialised to 0.
  - datapath_output: logic [31:0], always equals register x10 (a0).
- Load mode (test_write=1): on each rising clock, imem[program_counter[7:2]] <= dummy_instr_writedata. While loading:
  - PC does not advance.
  - No register-file or data-memory writes occur.
- Reset (KEY[3]=0, async):
  - program_counter=0.
  - x1..x31=0, so datapath_output=0 and LEDR=0.
  - Instruction and data memory are NOT cleared; a loaded program survives reset.
  - Release is synchronous to the next rising edge.
- Run mode (test_write=0, reset released): one instruction per clock.
  - Instruction fetch is a combinational read of imem[program_counter[7:2]].
  - Register-file writes occur at the rising edge; x0 always reads 0.
  - Reads are combinational, so a write in cycle N is visible in cycle N+1.
- Supported instructions:
  - R-type: ADD SUB AND OR XOR SLT SLTU SLL SRL SRA.
  - I-type: ADDI ANDI ORI XORI SLTI SLLI SRLI SRAI.
  - Memory: LW SW (word only; addr[1:0] ignored).
  - Control: BEQ BNE BLT BGE JAL JALR.
  - Upper: LUI.
- Arithmetic is 32-bit two's complement, overflow wraps. Shifts use the low 5 bits of the shift amount.
- Next PC:
  - default pc+4.
  - Taken branch and JAL: pc+imm.
  - JALR: (rs1+imm) & ~1.
  - All targets truncated to 8 bits, so 0xFC+4 wraps to 0x00.
- JAL/JALR write pc+4, zero-extended, into rd.
- Unknown opcodes execute as NOP (pc+4, no writes).
- Display:
  - HEX5..HEX0 show the 24-bit value: datapath_output[23:0] when SW[0]=0, {16'h0,program_counter} when SW[0]=1.
  - Standard hex glyphs 0-F; a lit segment is a 0 bit.

Optional Feature:
- HEX_DISPLAY_EN defined: seven-segment decode as described above.
- Undefined: HEX0..HEX5 driven constant 7'h7F (all off), and the decoders are removed.
- LEDR and all CPU behaviour are identical either way.

Test Plan:
- Load 16 words via test_write with program_counter=0,4,..,60, then reset.
  - Required: PC=0 after reset; imem contents intact; fetch at 0 returns the first loaded word.
- Program "ADDI x10,x0,1".
  - Required: datapath_output rises 0->1 on the first edge after reset release; LEDR=10'h001; HEX0=7'h79; HEX1..5=7'h40.
- Program "ADDI x1,x0,5; ADDI x2,x0,-3; ADD x10,x1,x2".
  - Required: datapath_output=2 after 3 cycles.
- Loop "ADDI x5,x0,3; ADDI x5,x5,-1; BNE x5,x0,-4; ADDI x10,x0,1".
  - Required: datapath_output[0] rises on cycle 8 after reset.
- "ADDI x1,x0,0x55; SW x1,8(x0); LW x10,8(x0)".
  - Required: datapath_output=0x55.
  - Then assert KEY[3]=0 mid-run: PC and datapath_output go to 0 immediately, without waiting for a clock edge.
- With SW[0]=1, halted at a JAL x0,0 loop at pc=0x0C.
  - Required: HEX0=glyph C (7'h46), HEX1=glyph 0 (7'h40).

Source files
------------

// File: rtl/riscv_top_level.sv
// riscv_top_level: board-level single-cycle RV32I computer for a 50 MHz board.
// One instruction retires per CLOCK_50 edge. Instruction and data memories
// are plain word arrays that reset does not clear, so a program preloaded
// through the load hooks (test_write / dummy_instr_writedata) survives reset.
// Optional build macro HEX_DISPLAY_EN: when defined, HEX5..HEX0 show a
// 24-bit value as hex glyphs; when undefined the decoders are removed and
// every digit is driven dark.
module riscv_top_level #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 64
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    // opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // ALU operations
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // writeback sources
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_LUI = 2'd3;

    typedef struct packed {
        logic       reg_we;
        logic       mem_we;
        logic       alu_src_imm;
        logic [3:0] alu_op;
        logic [1:0] wb_sel;
        logic       branch;
        logic       jal;
        logic       jalr;
    } ctrl_t;

    logic rst_n;
    assign rst_n = KEY[3];

    // Load hooks: the bench writes these hierarchically; no RTL driver.
    logic        test_write            = 1'b0;
    logic [31:0] dummy_instr_writedata = 32'h0;

    logic [7:0]  program_counter;
    logic [31:0] datapath_output;

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    logic        cpu_run;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] alu_imm, alu_b, alu_result;
    logic [31:0] mem_rdata, wb_data;
    logic [7:0]  pc_plus4, pc_next;
    logic        br_taken;
    ctrl_t       ctrl;

    // CPU state only changes when not loading and not in reset
    assign cpu_run = !test_write && rst_n;

    //--------------------------------------------------------------------
    // Fetch and field extraction
    //--------------------------------------------------------------------
    assign instr  = imem[program_counter[IAW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};

    // x0 is hardwired to zero on read; it is never written either
    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2];

    //--------------------------------------------------------------------
    // Decode: anything unrecognised leaves ctrl at zero, i.e. a NOP
    //--------------------------------------------------------------------
    // Build the control word from opcode/funct fields
    always_comb begin
        ctrl        = '0;
        ctrl.alu_op = ALU_ADD;
        unique case (opcode)
            OP_R: begin
                ctrl.reg_we = 1'b1;
                case ({funct7, funct3})
                    10'b0000000_000: ctrl.alu_op = ALU_ADD;
                    10'b0100000_000: ctrl.alu_op = ALU_SUB;
                    10'b0000000_111: ctrl.alu_op = ALU_AND;
                    10'b0000000_110: ctrl.alu_op = ALU_OR;
                    10'b0000000_100: ctrl.alu_op = ALU_XOR;
                    10'b0000000_010: ctrl.alu_op = ALU_SLT;
                    10'b0000000_011: ctrl.alu_op = ALU_SLTU;
                    10'b0000000_001: ctrl.alu_op = ALU_SLL;
                    10'b0000000_101: ctrl.alu_op = ALU_SRL;
                    10'b0100000_101: ctrl.alu_op = ALU_SRA;
                    default:         ctrl.reg_we = 1'b0;
                endcase
            end
            OP_I: begin
                ctrl.reg_we      = 1'b1;
                ctrl.alu_src_imm = 1'b1;
                case (funct3)
                    3'b000: ctrl.alu_op = ALU_ADD;
                    3'b111: ctrl.alu_op = ALU_AND;
                    3'b110: ctrl.alu_op = ALU_OR;
                    3'b100: ctrl.alu_op = ALU_XOR;
                    3'b010: ctrl.alu_op = ALU_SLT;
                    3'b001: begin
                        ctrl.alu_op = ALU_SLL;
                        if (funct7 != 7'b0000000) ctrl.reg_we = 1'b0;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      ctrl.alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) ctrl.alu_op = ALU_SRA;
                        else                           ctrl.reg_we = 1'b0;
                    end
                    default: ctrl.reg_we = 1'b0;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    ctrl.reg_we      = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.wb_sel      = WB_MEM;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    ctrl.mem_we      = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                end
            end
            OP_BRANCH: ctrl.branch = 1'b1;
            OP_JAL: begin
                ctrl.reg_we = 1'b1;
                ctrl.jal    = 1'b1;
                ctrl.wb_sel = WB_PC4;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl.reg_we      = 1'b1;
                    ctrl.jalr        = 1'b1;
                    ctrl.alu_src_imm = 1'b1;
                    ctrl.wb_sel      = WB_PC4;
                end
            end
            OP_LUI: begin
                ctrl.reg_we = 1'b1;
                ctrl.wb_sel = WB_LUI;
            end
            default: ctrl = '0;
        endcase
    end

    //--------------------------------------------------------------------
    // Execute
    //--------------------------------------------------------------------
    assign alu_imm = (opcode == OP_STORE) ? imm_s : imm_i;
    assign alu_b   = ctrl.alu_src_imm ? alu_imm : rs2_val;

    // 32-bit ALU; shifts honour only the low 5 bits of the amount
    always_comb begin
        alu_result = 32'h0;
        case (ctrl.alu_op)
            ALU_ADD:  alu_result = rs1_val + alu_b;
            ALU_SUB:  alu_result = rs1_val - alu_b;
            ALU_AND:  alu_result = rs1_val & alu_b;
            ALU_OR:   alu_result = rs1_val | alu_b;
            ALU_XOR:  alu_result = rs1_val ^ alu_b;
            ALU_SLT:  alu_result = {31'h0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU: alu_result = {31'h0, rs1_val < alu_b};
            ALU_SLL:  alu_result = rs1_val << alu_b[4:0];
            ALU_SRL:  alu_result = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(rs1_val) >>> alu_b[4:0]);
            default:  alu_result = 32'h0;
        endcase
    end

    // Branch condition; unsupported funct3 encodings never take
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = (rs1_val == rs2_val);
            3'b001:  br_taken = (rs1_val != rs2_val);
            3'b100:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            default: br_taken = 1'b0;
        endcase
    end

    //--------------------------------------------------------------------
    // Next PC: everything is 8 bits wide, so targets wrap naturally
    //--------------------------------------------------------------------
    assign pc_plus4 = program_counter + 8'd4;

    // Select sequential, PC-relative or register-indirect successor
    always_comb begin
        pc_next = pc_plus4;
        if (ctrl.jal)
            pc_next = program_counter + imm_j[7:0];
        else if (ctrl.branch && br_taken)
            pc_next = program_counter + imm_b[7:0];
        else if (ctrl.jalr)
            pc_next = alu_result[7:0] & 8'hFE;
    end

    // PC holds while loading so the bench can steer the load address
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)
            program_counter <= 8'h00;
        else if (!test_write)
            program_counter <= pc_next;
    end

    //--------------------------------------------------------------------
    // Memories (never reset: a loaded program must survive KEY[3])
    //--------------------------------------------------------------------
    // Instruction memory is written only through the load hook
    always_ff @(posedge CLOCK_50) begin
        if (test_write)
            imem[program_counter[IAW+1:2]] <= dummy_instr_writedata;
    end

    // Word-only data memory; byte offset bits are ignored
    always_ff @(posedge CLOCK_50) begin
        if (cpu_run && ctrl.mem_we)
            dmem[alu_result[DAW+1:2]] <= rs2_val;
    end

    assign mem_rdata = dmem[alu_result[DAW+1:2]];

    //--------------------------------------------------------------------
    // Writeback / register file
    //--------------------------------------------------------------------
    // Pick the value retired into rd
    always_comb begin
        wb_data = alu_result;
        case (ctrl.wb_sel)
            WB_ALU:  wb_data = alu_result;
            WB_MEM:  wb_data = mem_rdata;
            WB_PC4:  wb_data = {24'h0, pc_plus4};
            WB_LUI:  wb_data = imm_u;
            default: wb_data = alu_result;
        endcase
    end

    // Register file clears on reset; x0 is never written
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else if (!test_write && ctrl.reg_we && (rd != 5'd0)) begin
            rf[rd] <= wb_data;
        end
    end

    assign datapath_output = rf[10];
    assign LEDR            = datapath_output[9:0];

    //--------------------------------------------------------------------
    // Seven-segment display
    //--------------------------------------------------------------------
`ifdef HEX_DISPLAY_EN
    logic [23:0] disp_val;

    // Active-low gfedcba glyphs for one hex nibble
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    assign disp_val = SW[0] ? {16'h0, program_counter} : datapath_output[23:0];
    assign HEX0 = hex_glyph(disp_val[3:0]);
    assign HEX1 = hex_glyph(disp_val[7:4]);
    assign HEX2 = hex_glyph(disp_val[11:8]);
    assign HEX3 = hex_glyph(disp_val[15:12]);
    assign HEX4 = hex_glyph(disp_val[19:16]);
    assign HEX5 = hex_glyph(disp_val[23:20]);

    logic unused_bits;
    assign unused_bits = &{1'b0, KEY[2:0], SW[9:1], datapath_output[31:24],
                           imm_b[31:8], imm_j[31:8]};
`else
    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;

    logic unused_bits;
    assign unused_bits = &{1'b0, KEY[2:0], SW[9:0], datapath_output[31:10],
                           imm_b[31:8], imm_j[31:8]};
`endif

endmodule

// File: tb/tb_riscv_top_level.sv
// tb_riscv_top_level: preloads programs through the load hooks, runs them
// from reset, and compares datapath_output / PC / LEDR / HEX against values
// queued when each program is started.
module tb_riscv_top_level;

    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] sw;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

    always #10 clk = ~clk;

    riscv_top_level dut (
        .CLOCK_50 (clk),
        .KEY      (key),
        .SW       (sw),
        .LEDR     (ledr),
        .HEX0     (hex0),
        .HEX1     (hex1),
        .HEX2     (hex2),
        .HEX3     (hex3),
        .HEX4     (hex4),
        .HEX5     (hex5)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    logic [31:0] pw    [$];
    logic [31:0] img   [16];
    logic [7:0]  ld_pc;
    logic [6:0]  glyph [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) chk({tag, "_noexp"}, 32'(exp_q.size()), 32'd1);
        else                   chk(tag, obs, exp_q.pop_front());
    endtask

    // instruction encoders
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        logic [31:0] m = imm;
        return {m[11:0], 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] srai(input int rd, input int rs1, input int sh);
        return {7'h20, 5'(sh), 5'(rs1), 3'b101, 5'(rd), 7'h13};
    endfunction
    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] sw_i(input int rs2, input int rs1, input int imm);
        logic [31:0] m = imm;
        return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lw_i(input int rd, input int rs1, input int imm);
        logic [31:0] m = imm;
        return {m[11:0], 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction
    function automatic logic [31:0] bne(input int rs1, input int rs2, input int imm);
        logic [31:0] m = imm;
        return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'b001, m[4:1], m[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] m = imm;
        return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #5;
        end
    endtask

    // one load-mode write at a steered PC
    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        ld_pc = a;
        force dut.program_counter = ld_pc;
        dut.dummy_instr_writedata = d;
        step(1);
    endtask

    // load pw (padded with a JAL x0,0 halt) at 0..60 under reset, then release
    task automatic start();
        key[3] = 1'b0;
        #1;
        dut.test_write = 1'b1;
        for (int i = 0; i < 16; i++)
            load_word(8'(i * 4), (i < pw.size()) ? pw[i] : jal(0, 0));
        dut.test_write = 1'b0;
        release dut.program_counter;
        step(1);
        key[3] = 1'b1;
    endtask

    initial begin
`ifdef HEX_DISPLAY_EN
        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
        for (int i = 0; i < 16; i++) glyph[i] = 7'h7F;
`endif
        key = 4'h0;
        sw  = 10'h0;
        step(2);

        // reset state
        push(32'h0); pop_chk("rst_pc", 32'(dut.program_counter));
        push(32'h0); pop_chk("rst_dp", dut.datapath_output);
        push(32'h0); pop_chk("rst_ledr", 32'(ledr));

        // load 16 words with reset released; loading must not retire anything
        img[0] = addi(10, 0, 1);
        img[1] = jal(0, 0);
        for (int i = 2; i < 16; i++) img[i] = addi(0, 0, i);
        dut.test_write = 1'b1;
        ld_pc = 8'h00;
        force dut.program_counter = ld_pc;
        key[3] = 1'b1;
        for (int i = 0; i < 16; i++) load_word(8'(i * 4), img[i]);
        push(32'h0); pop_chk("load_nowrite", dut.datapath_output);
        key[3] = 1'b0;
        dut.test_write = 1'b0;
        release dut.program_counter;
        step(1);
        push(32'h0); pop_chk("load_rst_pc", 32'(dut.program_counter));
        for (int i = 0; i < 16; i++) begin
            push(img[i]);
            pop_chk($sformatf("imem%0d", i), dut.imem[i]);
        end
        push(img[0]); pop_chk("fetch0", dut.instr);

        // ADDI x10,x0,1: visible on the first edge after release
        key[3] = 1'b1;
        push(32'h0); pop_chk("addi_pre", dut.datapath_output);
        step(1);
        push(32'h1);  pop_chk("addi_dp", dut.datapath_output);
        push(32'h1);  pop_chk("addi_ledr", 32'(ledr));
        push(32'(glyph[1])); pop_chk("addi_hex0", 32'(hex0));
        push(32'(glyph[0])); pop_chk("addi_hex1", 32'(hex1));
        push(32'(glyph[0])); pop_chk("addi_hex5", 32'(hex5));

        // 5 + (-3)
        pw.delete();
        pw.push_back(addi(1, 0, 5));
        pw.push_back(addi(2, 0, -3));
        pw.push_back(add(10, 1, 2));
        start();
        push(32'h2);
        step(3);
        pop_chk("add_dp", dut.datapath_output);

        // countdown loop: x10 set on edge 8
        pw.delete();
        pw.push_back(addi(5, 0, 3));
        pw.push_back(addi(5, 5, -1));
        pw.push_back(bne(5, 0, -4));
        pw.push_back(addi(10, 0, 1));
        start();
        push(32'h0); push(32'h1);
        step(7);
        pop_chk("loop_c7", 32'(dut.datapath_output[0]));
        step(1);
        pop_chk("loop_c8", 32'(dut.datapath_output[0]));

        // store then load back, then async reset mid-cycle
        pw.delete();
        pw.push_back(addi(1, 0, 32'h55));
        pw.push_back(sw_i(1, 0, 8));
        pw.push_back(lw_i(10, 0, 8));
        start();
        push(32'h55); push(32'h0); push(32'h0); push(32'h0);
        step(3);
        pop_chk("swlw_dp", dut.datapath_output);
        #2 key[3] = 1'b0;
        #1;
        pop_chk("async_pc", 32'(dut.program_counter));
        pop_chk("async_dp", dut.datapath_output);
        pop_chk("async_ledr", 32'(ledr));

        // arithmetic shift of a negative value
        pw.delete();
        pw.push_back(addi(1, 0, -8));
        pw.push_back(srai(10, 1, 1));
        start();
        push(32'hFFFF_FFFC); push(32'h3FC);
        step(2);
        pop_chk("srai_dp", dut.datapath_output);
        pop_chk("srai_ledr", 32'(ledr));

        // JAL links pc+4
        pw.delete();
        pw.push_back(jal(10, 8));
        pw.push_back(addi(10, 0, 9));
        start();
        push(32'h4); push(32'h8);
        step(1);
        pop_chk("jal_link", dut.datapath_output);
        pop_chk("jal_pc", 32'(dut.program_counter));

        // PC wrap: JAL -4 from 0 lands at 0xFC, whose successor is 0x00
        key[3] = 1'b0;
        #1;
        dut.test_write = 1'b1;
        load_word(8'hFC, addi(10, 0, 7));
        dut.test_write = 1'b0;
        release dut.program_counter;
        pw.delete();
        pw.push_back(jal(0, -4));
        start();
        push(32'hFC); push(32'h7); push(32'h0);
        step(1);
        pop_chk("wrap_tgt", 32'(dut.program_counter));
        step(1);
        pop_chk("wrap_dp", dut.datapath_output);
        pop_chk("wrap_pc", 32'(dut.program_counter));

        // halt at 0x0C, display the PC
        pw.delete();
        pw.push_back(addi(0, 0, 0));
        pw.push_back(addi(0, 0, 0));
        pw.push_back(addi(0, 0, 0));
        start();
        sw[0] = 1'b1;
        push(32'h0C);
        push(32'(glyph[12])); push(32'(glyph[0])); push(32'(glyph[0]));
        step(6);
        pop_chk("halt_pc", 32'(dut.program_counter));
        pop_chk("halt_hex0", 32'(hex0));
        pop_chk("halt_hex1", 32'(hex1));
        pop_chk("halt_hex4", 32'(hex4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
